// File: rtl/unary_pkg.sv
// Shared types and constants for the unary stream generator and its per-channel bit generators.
package unary_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic MODE_THERMO = 1'b0;
  localparam logic MODE_DITHER = 1'b1;

  function automatic int unsigned frame_len(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/unary_bit_gen.sv
// One unary channel: holds the operand and the first-order modulator accumulator,
// and presents the bit for the current frame index combinationally.
module unary_bit_gen
  import unary_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic         mode,
  input  logic [W-1:0] value,
  input  logic [W-1:0] cnt,
  output logic         ubit
);

  localparam int unsigned FRAME   = frame_len(W);
  localparam logic [W:0]  FRAME_X = (W+1)'(FRAME);

  logic [W-1:0] v_q;
  logic [W-1:0] acc;
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic         hit;

  always_comb begin
    sum  = {1'b0, acc} + {1'b0, v_q};
    diff = sum - FRAME_X;
    hit  = (sum >= FRAME_X);
    ubit = (mode == MODE_DITHER) ? hit : (cnt < v_q);
  end

  // load wins over step so a back-to-back accept restarts the accumulator cleanly
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      acc <= '0;
    end else if (load) begin
      v_q <= value;
      acc <= '0;
    end else if (step && (mode == MODE_DITHER)) begin
      acc <= hit ? diff[W-1:0] : sum[W-1:0];
    end
  end

endmodule

// File: rtl/unary_stream_gen.sv
// Converts two binary operands into serial unary streams A/B with frame enable,
// one bit per non-held RUN cycle, registered outputs, zero-gap back-to-back frames.
module unary_stream_gen
  import unary_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_val,
  input  logic [W-1:0] b_val,
  input  logic         mode,
  input  logic         hold,
  output logic         A,
  output logic         B,
  output logic         en,
  output logic         frame_done,
  output logic         busy
);

  localparam int unsigned FRAME = frame_len(W);
  localparam logic [W-1:0] LAST = W'(FRAME - 1);

  state_t       state;
  state_t       state_next;
  logic [W-1:0] cnt;
  logic         mode_q;
  logic         at_last;
  logic         step;
  logic         accept;
  logic         bit_a;
  logic         bit_b;

  always_comb begin
    at_last    = (state == RUN) && (cnt == LAST);
    step       = (state == RUN) && !hold;
    in_ready   = !rst && ((state == IDLE) || (at_last && !hold));
    accept     = in_valid && in_ready;
    state_next = state;
    if (accept) begin
      state_next = RUN;
    end else if (step && at_last) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mode_q     <= MODE_THERMO;
      A          <= 1'b0;
      B          <= 1'b0;
      en         <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt    <= '0;
        mode_q <= mode;
      end else if (step) begin
        cnt <= cnt + 1'b1;
      end
      // bit computed from the pre-edge index, so it is shown one cycle later
      en         <= step;
      A          <= step && bit_a;
      B          <= step && bit_b;
      frame_done <= step && at_last;
      busy       <= accept || (state == RUN);
    end
  end

  unary_bit_gen #(.W(W)) u_gen_a (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .step  (step),
    .mode  (mode_q),
    .value (a_val),
    .cnt   (cnt),
    .ubit  (bit_a)
  );

  unary_bit_gen #(.W(W)) u_gen_b (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .step  (step),
    .mode  (mode_q),
    .value (b_val),
    .cnt   (cnt),
    .ubit  (bit_b)
  );

endmodule

// File: tb/tb_unary_stream_gen.sv
// Self-checking bench for unary_stream_gen: per-cycle behavioural model plus directed frame patterns.
module tb_unary_stream_gen;

  localparam int W = 4;
  localparam int F = 15;

  logic         clk = 1'b0;
  logic         rst, in_valid, mode, hold;
  logic [W-1:0] a_val, b_val;
  logic         in_ready, A, B, en, frame_done, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  unary_stream_gen #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_val      (a_val),
    .b_val      (b_val),
    .mode       (mode),
    .hold       (hold),
    .A          (A),
    .B          (B),
    .en         (en),
    .frame_done (frame_done),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Bit i of a frame carrying value v: thermometer is ones-first, dithered is the
  // closed-form evenly spread sequence floor((i+1)v/F) - floor(iv/F).
  function automatic logic ref_bit(input int v, input logic md, input int i);
    if (!md) return logic'(i < v);
    return logic'((((i + 1) * v) / F) != ((i * v) / F));
  endfunction

  // Model state
  logic m_active = 1'b0;
  int   m_idx = 0, m_a = 0, m_b = 0;
  logic m_md = 1'b0;
  logic model_ok = 1'b0;
  logic e_A, e_B, e_en, e_fd, e_busy, exp_ready, m_acc, m_emit;

  // Frame capture
  int          cyc = 0;
  logic [F-1:0] cur_a = '0, cur_b = '0, last_a = '0, last_b = '0;
  int          cur_en = 0, last_en = 0, frames_done = 0;
  int          first_cyc = 0, last_span = 0, last_done_cyc = 0, prev_done_cyc = 0;
  int          run = 0, max_run = 0;
  int          pa_q[$], pb_q[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (model_ok) begin
        chk("A", A, e_A);
        chk("B", B, e_B);
        chk("en", en, e_en);
        chk("frame_done", frame_done, e_fd);
        chk("busy", busy, e_busy);
      end

      if (busy !== 1'b1) begin
        cur_en = 0; cur_a = '0; cur_b = '0;
      end
      if (en === 1'b1) begin
        if (cur_en == 0) first_cyc = cyc;
        if (cur_en < F) begin
          cur_a[cur_en] = A;
          cur_b[cur_en] = B;
        end
        cur_en++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (frame_done === 1'b1) begin
        last_a = cur_a; last_b = cur_b; last_en = cur_en;
        last_span = cyc - first_cyc + 1;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        pa_q.push_back($countones(cur_a));
        pb_q.push_back($countones(cur_b));
        frames_done++;
        cur_en = 0; cur_a = '0; cur_b = '0;
      end

      exp_ready = !rst && (!m_active || ((m_idx == F - 1) && !hold));
      if (model_ok) chk("in_ready", in_ready, exp_ready);

      if (rst === 1'b1) begin
        m_active = 1'b0; m_idx = 0;
        {e_A, e_B, e_en, e_fd, e_busy} = '0;
        model_ok = 1'b1;
      end else if (model_ok) begin
        m_acc  = in_valid && exp_ready;
        m_emit = m_active && !hold;
        e_en   = m_emit;
        e_A    = m_emit && ref_bit(m_a, m_md, m_idx);
        e_B    = m_emit && ref_bit(m_b, m_md, m_idx);
        e_fd   = m_emit && (m_idx == F - 1);
        e_busy = m_active || m_acc;
        if (m_emit) begin
          m_idx++;
          if (m_idx == F) m_active = 1'b0;
        end
        if (m_acc) begin
          m_active = 1'b1; m_idx = 0;
          m_a = int'(a_val); m_b = int'(b_val); m_md = mode;
        end
      end
    end
  end

  task automatic offer(input int a, input int b, input logic m);
    logic r;
    int   n;
    r = 1'b0;
    n = 0;
    a_val = W'(a); b_val = W'(b); mode = m; in_valid = 1'b1;
    do begin
      @(negedge clk); #1 r = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!r && n < 100);
    in_valid = 1'b0;
    if (!r) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_frames(input int target);
    int k;
    k = 0;
    while (frames_done < target && k < 300) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (frames_done < target) chk("frame_timeout", frames_done, target);
  endtask

  int base;

  initial begin
    rst = 1'b1; in_valid = 1'b0; hold = 1'b0; mode = 1'b0; a_val = '0; b_val = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_en", en, 0);

    // thermometer 5/3
    base = frames_done;
    offer(5, 3, 1'b0);
    wait_frames(base + 1);
    chk("thermo_a", last_a, 15'h001F);
    chk("thermo_b", last_b, 15'h0007);
    chk("thermo_en", last_en, 15);
    chk("thermo_busy_drop", busy, 0);

    // dithered 5/3
    base = frames_done;
    offer(5, 3, 1'b1);
    wait_frames(base + 1);
    chk("dither_a", last_a, 15'h4924);
    chk("dither_b", last_b, 15'h4210);

    // extremes in both modes
    for (int m = 0; m < 2; m++) begin
      base = frames_done;
      offer(0, 15, logic'(m));
      wait_frames(base + 1);
      chk("edge_a0", last_a, 15'h0000);
      chk("edge_b15", last_b, 15'h7FFF);
      base = frames_done;
      offer(15, 0, logic'(m));
      wait_frames(base + 1);
      chk("edge_a15", last_a, 15'h7FFF);
      chk("edge_b0", last_b, 15'h0000);
    end

    // back-to-back frames
    repeat (2) @(posedge clk);
    #1 max_run = 0;
    base = frames_done;
    offer(7, 2, 1'b0);
    offer(1, 9, 1'b0);
    wait_frames(base + 2);
    chk("b2b_run", max_run, 30);
    chk("b2b_done_gap", last_done_cyc - prev_done_cyc, 15);
    chk("b2b_pa0", pa_q[base], 7);
    chk("b2b_pb0", pb_q[base], 2);
    chk("b2b_pa1", pa_q[base + 1], 1);
    chk("b2b_pb1", pb_q[base + 1], 9);

    // hold for 4 cycles after 6 bits
    base = frames_done;
    offer(8, 0, 1'b0);
    repeat (6) @(posedge clk);
    #1 hold = 1'b1;
    repeat (4) @(posedge clk);
    #1 hold = 1'b0;
    wait_frames(base + 1);
    chk("hold_span", last_span, 19);
    chk("hold_en", last_en, 15);
    chk("hold_pop", $countones(last_a), 8);

    // reset mid-frame after 8 bits
    base = frames_done;
    offer(9, 9, 1'b1);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_en", en, 0);
    chk("abort_ready", in_ready, 1);
    repeat (20) @(posedge clk);
    #1 chk("abort_no_done", frames_done, base);
    offer(4, 4, 1'b0);
    wait_frames(base + 1);
    chk("after_abort_a", last_a, 15'h000F);
    chk("after_abort_en", last_en, 15);

    // randomized traffic against the per-cycle model
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      in_valid = ($urandom_range(0, 3) != 0);
      a_val    = W'($urandom_range(0, 15));
      b_val    = W'($urandom_range(0, 15));
      mode     = logic'($urandom_range(0, 1));
      hold     = ($urandom_range(0, 4) == 0);
      rst      = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0; hold = 1'b0; rst = 1'b0;
    repeat (40) @(posedge clk);
    #1 chk("drain_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unary_stream_gen.md
Name: unary_stream_gen

Overview:
- Upstream source stage for the unary adder. Converts two W-bit binary operands into two serial unary bitstreams A and B, plus a frame enable en, over a fixed frame of FRAME = 2^W-1 cycles.
- The downstream adder counts ones on A and B while en=1, so over one frame it accumulates exactly a_val+b_val ones.
- Two encodings: thermometer (ones first) and dithered (first-order modulator, ones spread evenly).

Parameters:
- W, 4, operand width. Localparam FRAME = 2^W-1 (15 at default).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block accepts operands this cycle.
- a_val  in  W  operand A, range 0..FRAME.
- b_val  in  W  operand B, range 0..FRAME.
- mode  in  1  0 = thermometer, 1 = dithered; sampled at accept.
- hold  in  1  stall the running frame.
- A  out  1  unary bit, channel A.
- B  out  1  unary bit, channel B.
- en  out  1  A/B bit valid this cycle.
- frame_done  out  1  one-cycle pulse coincident with the last bit of a frame.
- busy  out  1  frame in progress.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; A, B, en, frame_done, busy = 0; cnt=0; accumulators=0.
  - in_ready is forced 0 while rst=1.
  - Reset mid-frame abandons the frame immediately: no frame_done, no remaining bits.
- States: IDLE and RUN.
- Accept: in_valid & in_ready at edge T. Latch a_val, b_val and mode; cnt=0; accA=accB=0; state=RUN.
- Output timing: all outputs except in_ready are registered. The first bit appears on A/B/en in the cycle after T, i.e. latency is 1 cycle.
- Per RUN cycle with hold=0, one bit is emitted, with index cnt = 0..FRAME-1:
  - Thermometer: A = (cnt < a_q); B = (cnt < b_q).
  - Dithered, per channel: sum = acc + v_q (W+1 bits).
    - If sum >= FRAME: bit=1, acc = sum-FRAME.
    - Otherwise: bit=0, acc = sum.
  - In both modes each channel emits exactly v_q ones per frame.
  - en=1 for that bit; cnt increments.
- hold=1 in RUN:
  - The next output cycle has en=0 and A=B=0.
  - cnt and the accumulators are frozen.
  - Multiple consecutive hold cycles are allowed. A frame therefore always contains exactly FRAME en=1 cycles.
- Last bit (cnt=FRAME-1, hold=0):
  - frame_done=1 together with that bit.
  - State returns to IDLE unless a new accept occurs in the same cycle.
- in_ready (combinational, from registered state and hold) = !rst & (IDLE | (RUN & cnt==FRAME-1 & !hold)).
  - An accept on the last-bit cycle starts the next frame with no gap: en stays 1 continuously across frames.
- IDLE outputs: en=0, A=B=0, busy=0.
- busy=1 from the cycle after accept through the cycle of the last bit.
- Values: operands are used unmodified. 0 gives all zeros; FRAME gives all ones. There is no value above FRAME at W bits.
- hold while IDLE has no effect. in_valid while busy and not ready is ignored; the operands must be held by the source.

Decomposition:
- Package unary_pkg:
  - state enum {IDLE, RUN}.
  - mode constants MODE_THERMO=0, MODE_DITHER=1.
  - function frame_len(W) = 2^W-1.
- Sub-module unary_bit_gen, one channel, instantiated twice for A and B.
  - Holds the value register and the modulator accumulator.
  - Inputs: load, step, mode, cnt.
  - Output: bit.
- The top level owns the FSM, cnt, the handshake and the output registers.

Test Plan:
1. Thermometer, a=5, b=3, hold=0 -> 15 en cycles; A=1 on en cycles 1-5, 0 on 6-15; B=1 on 1-3; frame_done on the 15th; busy drops the following cycle.
2. Dithered, a=5, b=3 -> A=1 on en cycles 3,6,9,12,15; B=1 on cycles 5,10,15; popcounts are 5 and 3.
3. Edges: a=0, b=15 in both modes -> A all 0, B all 1 over 15 en cycles; a=15, b=0 -> mirrored.
4. Back-to-back: in_valid held, pairs (7,2) then (1,9) -> 30 consecutive en=1 cycles with no gap; frame_done pulses on cycles 15 and 30; A popcounts 7 and 1; B popcounts 2 and 9.
5. Hold: a=8, hold=1 for 4 cycles after en cycle 6 -> 4 cycles with en=0 and A=B=0; the frame completes in 19 cycles with exactly 15 en cycles and A popcount 8.
6. Reset mid-frame after 8 bits -> next cycle A=B=en=busy=frame_done=0; after rst deasserts, in_ready=1; no frame_done for the aborted frame; a new accept of (4,4) produces a clean 15-cycle frame.
